// File: rtl/audio_pkg.sv
// audio_pkg: shared types and defaults for the audio mixer.
//   mix_state_e : mixer FSM state encoding
//   DEF_*       : default parameter values for audio_mixer / sat_shift
//   acc_width() : accumulator width that cannot overflow over a full mix
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC    = 2'd1,
      FINISH = 2'd2
   } mix_state_e;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_IN_WIDTH   = 8;
   localparam int DEF_GAIN_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_COUNT_BITS = 10;
   localparam int DEF_OUT_SHIFT  = 2;

   // One signed product needs in_w + gain_w + 1 bits; summing num_ch of
   // them adds clog2(num_ch) bits of headroom.
   function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
      return in_w + gain_w + 1 + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/sat_shift.sv
// sat_shift: arithmetic (floor) right shift followed by saturation to a
// signed OUT_W-bit range. Purely combinational.
//   acc_i : signed accumulator, IN_W bits
//   sat_o : signed result, OUT_W bits, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sat_shift
   import audio_pkg::*;
#(
   parameter int IN_W  = 19,
   parameter int SHIFT = DEF_OUT_SHIFT,
   parameter int OUT_W = DEF_DATA_WIDTH
) (
   input  logic signed [IN_W-1:0]  acc_i,
   output logic signed [OUT_W-1:0] sat_o
);

   // One spare bit so the clamp limits are representable whichever of
   // IN_W / OUT_W is wider.
   localparam int W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

   localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W-1:0] shifted;
   logic signed [W-1:0]    wide;

   assign shifted = acc_i >>> SHIFT;
   assign wide    = {{(W-IN_W){shifted[IN_W-1]}}, shifted};

   always_comb begin
      if (wide > SAT_MAX) begin
         sat_o = SAT_MAX[OUT_W-1:0];
      end else if (wide < SAT_MIN) begin
         sat_o = SAT_MIN[OUT_W-1:0];
      end else begin
         sat_o = wide[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: periodic multiply-accumulate mixer of NUM_CH unsigned
// (offset-binary) channels with per-channel gain and mute.
//   clk           : single clock
//   reset         : synchronous, active-high
//   div           : sample period in clk cycles (0 -> 2^COUNT_BITS)
//   in_ch         : packed unsigned samples, channel 0 in the LSBs
//   gain          : packed unsigned gains, channel 0 in the LSBs
//   mute          : per-channel mute, 1 excludes the channel
//   out           : signed mixed sample, held between updates
//   sample_strobe : one-cycle pulse when out updates
//   overrun       : sticky, set when a tick arrives while busy
//
// state  | meaning
// IDLE   | waiting for a tick; a tick snapshots inputs and clears acc
// ACC    | one channel per cycle added into acc from the snapshot
// FINISH | shift/saturate acc, present it on out, pulse sample_strobe
module audio_mixer
   import audio_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int IN_WIDTH   = DEF_IN_WIDTH,
   parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int COUNT_BITS = DEF_COUNT_BITS,
   parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [COUNT_BITS-1:0]          div,
   input  logic [NUM_CH*IN_WIDTH-1:0]     in_ch,
   input  logic [NUM_CH*GAIN_WIDTH-1:0]   gain,
   input  logic [NUM_CH-1:0]              mute,
   output logic signed [DATA_WIDTH-1:0]   out,
   output logic                           sample_strobe,
   output logic                           overrun
);

   localparam int ACC_W = acc_width(IN_WIDTH, GAIN_WIDTH, NUM_CH);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PRD_W = IN_WIDTH + GAIN_WIDTH + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   logic [COUNT_BITS-1:0]        count_q, count_d;
   logic                         tick_q, tick_d;
   mix_state_e                   state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic [NUM_CH*IN_WIDTH-1:0]   snap_in_q, snap_in_d;
   logic [NUM_CH*GAIN_WIDTH-1:0] snap_gain_q, snap_gain_d;
   logic [NUM_CH-1:0]            snap_mute_q, snap_mute_d;
   logic signed [DATA_WIDTH-1:0] out_q, out_d;
   logic                         overrun_q, overrun_d;

   logic [IN_WIDTH-1:0]          cur_in;
   logic [GAIN_WIDTH-1:0]        cur_gain;
   logic signed [IN_WIDTH-1:0]   centered;
   logic signed [PRD_W-1:0]      prd_a, prd_b, prd;
   logic signed [PRD_W-1:0]      term;
   logic signed [DATA_WIDTH-1:0] sat_val;

   // Sample divider. div-1 wraps to all ones for div=0, giving the full
   // 2^COUNT_BITS period. The compare is registered, so the FSM sees the
   // tick in the cycle after count hits div-1.
   always_comb begin
      tick_d  = (count_q == (div - COUNT_BITS'(1)));
      count_d = tick_d ? '0 : (count_q + COUNT_BITS'(1));
   end

   // Current channel term from the snapshot. Flipping the MSB turns the
   // offset-binary sample into two's complement (in - 2^(IN_WIDTH-1)).
   always_comb begin
      cur_in   = snap_in_q[idx_q*IN_WIDTH +: IN_WIDTH];
      cur_gain = snap_gain_q[idx_q*GAIN_WIDTH +: GAIN_WIDTH];
      centered = {~cur_in[IN_WIDTH-1], cur_in[IN_WIDTH-2:0]};
      prd_a    = {{(PRD_W-IN_WIDTH){centered[IN_WIDTH-1]}}, centered};
      prd_b    = {{(PRD_W-GAIN_WIDTH){1'b0}}, cur_gain};
      prd      = prd_a * prd_b;
      term     = snap_mute_q[idx_q] ? '0 : prd;
   end

   sat_shift #(
      .IN_W  (ACC_W),
      .SHIFT (OUT_SHIFT),
      .OUT_W (DATA_WIDTH)
   ) u_sat_shift (
      .acc_i (acc_q),
      .sat_o (sat_val)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      acc_d         = acc_q;
      snap_in_d     = snap_in_q;
      snap_gain_d   = snap_gain_q;
      snap_mute_d   = snap_mute_q;
      out_d         = out_q;
      overrun_d     = overrun_q | (tick_q && (state_q != IDLE));
      sample_strobe = 1'b0;
      out           = out_q;

      case (state_q)
         IDLE: begin
            if (tick_q) begin
               snap_in_d   = in_ch;
               snap_gain_d = gain;
               snap_mute_d = mute;
               acc_d       = '0;
               idx_d       = '0;
               state_d     = ACC;
            end
         end
         ACC: begin
            acc_d = acc_q + ACC_W'(term);
            if (idx_q == LAST_IDX) begin
               state_d = FINISH;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         FINISH: begin
            // Bypass so the new value is visible alongside the strobe;
            // out_q holds it afterwards.
            out_d         = sat_val;
            out           = sat_val;
            sample_strobe = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign overrun = overrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         tick_q      <= 1'b0;
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         snap_in_q   <= '0;
         snap_gain_q <= '0;
         snap_mute_q <= '0;
         out_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         tick_q      <= tick_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         snap_in_q   <= snap_in_d;
         snap_gain_q <= snap_gain_d;
         snap_mute_q <= snap_mute_d;
         out_q       <= out_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: default instance plus an OUT_SHIFT=0
// instance for saturation. Cycle numbers are relative to rel, the last
// clock edge that samples reset high.
module tb_audio_mixer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  div;
   logic [31:0] in_ch;
   logic [31:0] gain;
   logic [3:0]  mute;

   logic signed [15:0] out0, out1;
   logic               strobe0, strobe1;
   logic               ovr0, ovr1;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int rel = 0;

   audio_mixer u_dut0 (
      .clk           (clk),
      .reset         (reset),
      .div           (div),
      .in_ch         (in_ch),
      .gain          (gain),
      .mute          (mute),
      .out           (out0),
      .sample_strobe (strobe0),
      .overrun       (ovr0)
   );

   audio_mixer #(.OUT_SHIFT(0)) u_dut1 (
      .clk           (clk),
      .reset         (reset),
      .div           (div),
      .in_ch         (in_ch),
      .gain          (gain),
      .mute          (mute),
      .out           (out1),
      .sample_strobe (strobe1),
      .overrun       (ovr1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int c3, input int c2, input int c1, input int c0);
      return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      rel = cyc;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Finds the next strobe on the default instance and checks its cycle
   // and value; a missing strobe shows up as a cycle mismatch.
   task automatic wait_strobe(input string tag, input int exp_cyc, input int exp_out);
      int n;
      n = 0;
      @(negedge clk);
      while (!strobe0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_cyc"}, cyc, exp_cyc);
      chk({tag, "_out"}, out0, exp_out);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      div   = 10'd8;
      in_ch = '0;
      gain  = '0;
      mute  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", out0, 0);
      chk("rst_strobe", strobe0, 0);
      chk("rst_ovr", ovr0, 0);
      chk("rst_out1", out1, 0);
      chk("rst_ovr1", ovr1, 0);

      // ch0 only: (255-128)*128 >>> 2 = 4064
      in_ch = pk(0, 0, 0, 255);
      gain  = pk(0, 0, 0, 128);
      mute  = 4'b1110;
      do_reset();
      wait_strobe("ch0_first", rel + 13, 4064);
      @(negedge clk);
      chk("ch0_pulse", strobe0, 0);
      chk("ch0_hold", out0, 4064);
      wait_strobe("ch0_second", rel + 21, 4064);
      chk("ch0_no_ovr", ovr0, 0);

      // ch1 only: -128*64 >>> 2 = -2048
      in_ch = pk(0, 0, 0, 0);
      gain  = pk(0, 0, 64, 0);
      mute  = 4'b1101;
      do_reset();
      wait_strobe("ch1_neg", rel + 13, -2048);

      // ch2 only: -1*1 >>> 2 floors to -1
      in_ch = pk(0, 127, 0, 0);
      gain  = pk(0, 1, 0, 0);
      mute  = 4'b1011;
      do_reset();
      wait_strobe("floor_m1", rel + 13, -1);

      // 72*10 - 78*20 + 0*255 + 127*3 = -459 -> floor(-114.75) = -115
      in_ch = pk(255, 128, 50, 200);
      gain  = pk(3, 255, 20, 10);
      mute  = 4'b0000;
      do_reset();
      wait_strobe("mix4", rel + 13, -115);
      mute = 4'b1111;
      wait_strobe("all_muted", rel + 21, 0);

      // 4*127*255 = 129540; 4*-128*255 = -130560
      in_ch = pk(255, 255, 255, 255);
      gain  = pk(255, 255, 255, 255);
      mute  = 4'b0000;
      do_reset();
      wait_strobe("sat_hi_d0", rel + 13, 32385);
      chk("sat_hi_stb1", strobe1, 1);
      chk("sat_hi", out1, 32767);
      in_ch = pk(0, 0, 0, 0);
      wait_strobe("sat_lo_d0", rel + 21, -32640);
      chk("sat_lo", out1, -32768);

      // div=3: ticks at +3,+6,+9; +6 lands in ACC and is dropped
      div   = 10'd3;
      in_ch = pk(0, 0, 0, 255);
      gain  = pk(0, 0, 0, 128);
      mute  = 4'b1110;
      do_reset();
      wait_strobe("ovr_first", rel + 8, 4064);
      chk("ovr_set", ovr0, 1);
      in_ch = pk(0, 0, 0, 0);
      wait_strobe("ovr_second", rel + 14, -4096);

      // div=5: tick at +10 lands on FINISH and is dropped; next at +15
      div   = 10'd5;
      in_ch = pk(0, 0, 0, 255);
      do_reset();
      wait_strobe("fin_first", rel + 10, 4064);
      chk("fin_ovr_pre", ovr0, 0);
      wait_strobe("fin_second", rel + 20, 4064);
      chk("fin_ovr", ovr0, 1);

      // div=1: tick every cycle, one mix every 6 cycles
      div = 10'd1;
      do_reset();
      wait_strobe("div1_first", rel + 6, 4064);
      wait_strobe("div1_second", rel + 12, 4064);

      // reset pulsed during the second ACC cycle aborts the mix
      div = 10'd8;
      do_reset();
      wait_cyc(rel + 10);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rel = cyc;
      @(negedge clk);
      chk("abort_out", out0, 0);
      chk("abort_strobe", strobe0, 0);
      chk("abort_ovr", ovr0, 0);
      wait_strobe("abort_next", rel + 13, 4064);

      // inputs changed mid-ACC must not leak into the result
      do_reset();
      wait_cyc(rel + 10);
      in_ch = pk(0, 0, 0, 0);
      gain  = 32'hFFFF_FFFF;
      mute  = 4'b0000;
      wait_strobe("snapshot", rel + 13, 4064);

      // div lowered below the running count: wrap through 1024
      in_ch = pk(0, 0, 0, 255);
      gain  = pk(0, 0, 0, 128);
      mute  = 4'b1110;
      div   = 10'd8;
      do_reset();
      wait_cyc(rel + 6);
      div = 10'd4;
      wait_strobe("div_wrap", rel + 1033, 4064);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of mixed channels.
REQ-002 SHALL have parameter IN_WIDTH, default 8: unsigned channel sample width.
REQ-003 SHALL have parameter GAIN_WIDTH, default 8: unsigned per-channel gain width.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: signed output width, matching the downstream IIR filter input.
REQ-005 SHALL have parameter COUNT_BITS, default 10: sample divider width.
REQ-006 SHALL have parameter OUT_SHIFT, default 2: arithmetic right shift applied to the accumulator before saturation.
REQ-007 SHALL have port clk, input, 1: single clock for all logic.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port div, input, COUNT_BITS: sample period in clk cycles.
REQ-010 SHALL have port in_ch, input, NUM_CH*IN_WIDTH: packed unsigned channel samples, channel 0 in the LSBs.
REQ-011 SHALL have port gain, input, NUM_CH*GAIN_WIDTH: packed unsigned gains, channel 0 in the LSBs.
REQ-012 SHALL have port mute, input, NUM_CH: channel is excluded from the mix when its bit is 1.
REQ-013 SHALL have port out, output, DATA_WIDTH: signed mixed sample, held between updates.
REQ-014 SHALL have port sample_strobe, output, 1: high for exactly one cycle when out updates.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a tick is dropped.

Function
REQ-016 Divider: count SHALL increment every cycle, wrap to 0 at count==div-1, and generate tick on that cycle; div=0 SHALL give a period of 2^COUNT_BITS, div=1 SHALL give a tick every cycle.
REQ-017 FSM states: IDLE, ACC, FINISH; on a tick in IDLE, in_ch/gain/mute SHALL be snapshotted, acc cleared, ch index=0, and the FSM SHALL go to ACC.
REQ-018 ACC SHALL process one channel per cycle: term = (in - 2^(IN_WIDTH-1)) signed, times gain zero-extended, or 0 if muted; term SHALL be added to acc; the FSM SHALL go to FINISH after channel NUM_CH-1.
REQ-019 acc width SHALL be IN_WIDTH+GAIN_WIDTH+1+clog2(NUM_CH) so that no intermediate overflow occurs.
REQ-020 FINISH SHALL compute acc>>>OUT_SHIFT (arithmetic, floor), saturate it to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], register it to out, pulse sample_strobe, and return to IDLE.
REQ-021 Latency: sample_strobe SHALL assert NUM_CH+1 cycles after the tick cycle; out SHALL be valid in the same cycle as the strobe.
REQ-022 A tick arriving while the FSM is not IDLE SHALL be dropped, the in-flight mix SHALL be unaffected, and overrun SHALL be set.
REQ-023 A tick on the FINISH cycle SHALL also be dropped; the next accepted tick is the first tick in IDLE.
REQ-024 Inputs changing during ACC SHALL NOT affect the result, because only the snapshot is used.
REQ-025 div changing mid-period SHALL take effect at the next compare; if count already exceeds the new div-1, count SHALL wrap through 2^COUNT_BITS.

Reset
REQ-026 While reset is high: count=0, FSM=IDLE, acc=0, snapshot=0, out=0, sample_strobe=0, overrun=0.
REQ-027 Reset asserted mid-ACC SHALL abort the mix; no strobe SHALL follow, and out SHALL stay 0.
REQ-028 The first tick after reset release SHALL occur div cycles after release.

Structure
REQ-029 Package audio_pkg SHALL hold the FSM state enum, the default parameter constants, and the acc-width function.
REQ-030 One sub-module, sat_shift (arithmetic shift plus saturation, purely combinational), SHALL be instantiated in the FINISH path.
REQ-031 Target size is 120-400 RTL lines; out SHALL connect directly to the IIR filter input, with the same div value driving both blocks.

Verification
REQ-032 Defaults, div=8, ch0=255, gain0=128, ch1-3 muted -> out=4064, with strobe 5 cycles after each tick.
REQ-033 Defaults, ch1=0, gain1=64, others muted -> out=-2048 (exact floor).
REQ-034 OUT_SHIFT=0, all channels 255, gains 255 -> out=32767 (saturated high); all channels 0, gains 255 -> out=-32768.
REQ-035 div=3 (shorter than the 6-cycle mix) -> overrun=1, and each strobe carries a correct snapshot value.
REQ-036 Reset pulsed on the second ACC cycle -> no strobe, out=0, overrun=0, next strobe at release+div+5.
REQ-037 Change in_ch during ACC -> out equals the value computed from the snapshot taken at the tick.
